serial_sub: RTL and testbench

- Bit-serial two's-complement subtractor: computes diff = a - b, one bit per clock, LSB first.
- Uses a single full-subtractor cell and a registered borrow flop. It is the subtraction counterpart of the team's combinational adder cells.
- Sits beside the arithmetic datapath wherever area matters more than latency.
- Simple start/busy/done handshake; results are held stable until the next accepted start.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_sub_if.sv | 35 +++
 rtl/serial_sub_fs.sv | 17 +
 rtl/serial_sub.sv | 117 +++++++++++
 tb/tb_serial_sub.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared definitions for the bit-serial subtractor.
//   state_e             FSM state encoding (IDLE / SHIFT / DONE)
//   WIDTH_MIN/WIDTH_MAX legal range for the WIDTH parameter
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle of the bit-serial subtractor.
//   start      request, sampled only while the block is not busy
//   a, b       minuend / subtrahend, captured on an accepted start
//   busy       high while a subtraction is in progress
//   done       one-cycle pulse when diff/bout/ovf become valid
//   diff       a - b modulo 2^WIDTH
//   bout       unsigned borrow out (a < b)
//   ovf        signed overflow of a - b
//
// Handshake: start is accepted on a rising edge where start=1 and busy=0
// (IDLE or the DONE cycle). start while busy=1 is dropped, not queued.
// The result outputs change only on the edge that raises done, and hold
// their value until the next result edge.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_sub_fs.sv
// serial_sub_fs: combinational 1-bit full subtractor, computes x - y - bin.
//   x_i, y_i   operand bits
//   bin_i      borrow in
//   d_o        difference bit
//   bout_o     borrow out
module serial_sub_fs (
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = x_i ^ y_i ^ bin_i;
  assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, diff = a - b,
// one bit per clock, LSB first, through a single full-subtractor cell.
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   bus       serial_sub_if slave (start/a/b in, busy/done/diff/bout/ovf out)
//   state_o   current FSM state, for observation
// WIDTH must lie in WIDTH_MIN..WIDTH_MAX and match the interface WIDTH.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_sub_if.slave       bus,
  output state_e            state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sb_q, res_q, res_d;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             a_sign_q, b_sign_q;
  logic             cell_d, cell_bout;
  logic             load, last_bit;

  // A new request is taken in IDLE and also in the DONE cycle, which is
  // what allows back-to-back operation at one result per WIDTH+1 cycles.
  assign load     = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign res_d    = {cell_d, res_q[WIDTH-1:1]};

  serial_sub_fs u_fs (
    .x_i    (sa_q[0]),
    .y_i    (sb_q[0]),
    .bin_i  (borrow_q),
    .d_o    (cell_d),
    .bout_o (cell_bout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_d = ST_DONE;
      ST_DONE:  state_d = load ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      ST_SHIFT: bus.busy = 1'b1;
      ST_DONE:  bus.done = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: operand shifters, borrow flop, bit counter, result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      sa_q     <= bus.a;
      sb_q     <= bus.b;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      a_sign_q <= bus.a[WIDTH-1];
      b_sign_q <= bus.b[WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
      sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
      res_q    <= res_d;
      borrow_q <= cell_bout;
      cnt_q    <= cnt_q + CW'(1);
      // The visible result is a separate register so it holds steady while
      // the next operation is being shifted through res_q.
      if (last_bit) begin
        diff_q <= res_d;
        bout_q <= cell_bout;
        // Overflow only when operand signs differ and the result sign
        // disagrees with the minuend; cell_d is the result MSB here.
        ovf_q  <= (a_sign_q != b_sign_q) && (cell_d != a_sign_q);
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     checks = 0;
  int     errors = 0;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one accept edge, then drop start.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Bounded wait for done; lat counts edges after the accept edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!bus.done && lat < 30) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] d,
                              input logic bo, input logic ov);
    check({tag, ".diff"}, 32'(bus.diff), 32'(d));
    check({tag, ".bout"}, 32'(bus.bout), 32'(bo));
    check({tag, ".ovf"},  32'(bus.ovf),  32'(ov));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"},  32'(bus.busy),  32'd0);
    check({tag, ".done"},  32'(bus.done),  32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'(ST_IDLE));
    check_result(tag, 8'h00, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, busy_n, pulses;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    check_cleared("reset_hold");
    rst = 1'b0;
    tick();
    check_cleared("reset_release");

    // 0x5A - 0x3C: latency, busy length, single-cycle done
    launch(8'h5A, 8'h3C);
    check("t1.busy_after_accept", 32'(bus.busy), 32'd1);
    wait_done(lat, busy_n);
    check("t1.latency", 32'(lat), 32'd8);
    check("t1.busy_cycles", 32'(busy_n), 32'd8);
    check("t1.done_busy", 32'(bus.busy), 32'd0);
    check_result("t1", 8'h1E, 1'b0, 1'b0);
    tick();
    check("t1.done_pulse_width", 32'(bus.done), 32'd0);
    check("t1.idle", 32'(dbg_state), 32'(ST_IDLE));
    check_result("t1_hold", 8'h1E, 1'b0, 1'b0);

    // 0x00 - 0x01: unsigned borrow, no signed overflow
    launch(8'h00, 8'h01);
    wait_done(lat, busy_n);
    check("t2.latency", 32'(lat), 32'd8);
    check_result("t2", 8'hFF, 1'b1, 1'b0);
    tick();

    // -128 - 1: signed overflow, no borrow
    launch(8'h80, 8'h01);
    wait_done(lat, busy_n);
    check("t3.latency", 32'(lat), 32'd8);
    check_result("t3", 8'h7F, 1'b0, 1'b1);
    tick();

    // 127 - (-1): signed overflow and unsigned borrow
    launch(8'h7F, 8'hFF);
    wait_done(lat, busy_n);
    check("t4.latency", 32'(lat), 32'd8);
    check_result("t4", 8'h80, 1'b1, 1'b1);
    tick();

    // start while busy must be ignored
    launch(8'h10, 8'h01);
    bus.a = 8'hAA;
    bus.b = 8'h55;
    tick();
    tick();
    bus.a     = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 30) begin
      tick();
      lat++;
    end
    check("t5.latency", 32'(lat), 32'd5);
    check_result("t5", 8'h0F, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("t5.extra_done", 32'(pulses), 32'd0);
    check("t5.idle", 32'(dbg_state), 32'(ST_IDLE));

    // reset in the middle of SHIFT aborts and clears immediately
    launch(8'h5A, 8'h3C);
    tick();
    tick();
    tick();
    check("t6.busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_cleared("t6_async");
    tick();
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done) pulses++;
    end
    check("t6.no_done_after_abort", 32'(pulses), 32'd0);
    check_cleared("t6_after");
    launch(8'h33, 8'h44);
    wait_done(lat, busy_n);
    check("t6.latency", 32'(lat), 32'd8);
    check_result("t6_new", 8'hEF, 1'b1, 1'b0);
    tick();

    // back-to-back with start held high
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    bus.start = 1'b1;
    tick();
    wait_done(lat, busy_n);
    check("t7.first_latency", 32'(lat), 32'd8);
    check_result("t7_first", 8'h02, 1'b0, 1'b0);
    bus.a = 8'h03;
    bus.b = 8'h05;
    tick();
    lat = 1;
    while (!bus.done && lat < 30) begin
      check("t7.first_hold", 32'(bus.diff), 32'h02);
      tick();
      lat++;
    end
    bus.start = 1'b0;
    check("t7.done_spacing", 32'(lat), 32'd9);
    check_result("t7_second", 8'hFE, 1'b1, 1'b0);
    tick();
    check("t7.idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t7.done_low", 32'(bus.done), 32'd0);
    check_result("t7_hold", 8'hFE, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
